// File: rtl/mult_cell_pkg.sv
// Op encoding and operand-signedness helpers for the pipelined multiply cell.
package mult_cell_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSU = 2'd2,
    OP_MULXSS = 2'd3
  } op_e;

  function automatic logic is_high(input op_e op);
    return op != OP_MUL;
  endfunction

  function automatic logic src1_signed(input op_e op);
    return (op == OP_MULXSU) || (op == OP_MULXSS);
  endfunction

  function automatic logic src2_signed(input op_e op);
    return op == OP_MULXSS;
  endfunction

endpackage

// File: rtl/mult_cell_slice.sv
// One pipeline register slice: payload plus valid bit, held while en=0.
// Flush clears valid regardless of en; payload only loads on a valid beat so the last result is retained.
module mult_cell_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
      end
      if (en && in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mult_cell_pipe.sv
// Pipelined DATA_W x DATA_W multiply (MUL / MULXUU / MULXSU / MULXSS), LATENCY cycles when unstalled.
// Whole pipe holds while the output is valid and not taken; in_ready is the combinational inverse of that stall.
module mult_cell_pipe
  import mult_cell_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic [1:0]        op,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result
);

  localparam int H     = DATA_W / 2;
  localparam int PW    = 2 * DATA_W;
  localparam int PAY_W = 2 + PW;

  logic              stall;
  logic              en;
  logic              acc;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh, corr;
  logic [PAY_W-1:0]  tail_q;
  logic              tail_vld;
  logic [1:0]        tail_op;
  logic [PW-1:0]     tail_prod;

  // Unsigned product of the raw bit patterns, minus the sign-extension correction in the upper word.
  function automatic logic [PW-1:0] pp_sum(input logic [DATA_W-1:0] ll, lh, hl, hh, cr);
    return {hh, ll}
         + {{H{1'b0}}, lh, {H{1'b0}}}
         + {{H{1'b0}}, hl, {H{1'b0}}}
         - {cr, {DATA_W{1'b0}}};
  endfunction

  always_comb begin
    pp_ll = {{H{1'b0}}, src1[H-1:0]}      * {{H{1'b0}}, src2[H-1:0]};
    pp_lh = {{H{1'b0}}, src1[H-1:0]}      * {{H{1'b0}}, src2[DATA_W-1:H]};
    pp_hl = {{H{1'b0}}, src1[DATA_W-1:H]} * {{H{1'b0}}, src2[H-1:0]};
    pp_hh = {{H{1'b0}}, src1[DATA_W-1:H]} * {{H{1'b0}}, src2[DATA_W-1:H]};
    // A negative operand's value is its raw pattern minus 2^DATA_W; that term lands only in the high word.
    corr = '0;
    if (src1_signed(op_e'(op)) && src1[DATA_W-1]) corr = corr + src2;
    if (src2_signed(op_e'(op)) && src2[DATA_W-1]) corr = corr + src1;
  end

  assign stall    = tail_vld & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;
  assign acc      = in_valid & in_ready;

  if (LATENCY == 1) begin : g_lat1
    mult_cell_slice #(.W(PAY_W)) u_s1 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
      .in_valid(acc),
      .in_data({op, pp_sum(pp_ll, pp_lh, pp_hl, pp_hh, corr)}),
      .out_valid(tail_vld), .out_data(tail_q)
    );
  end else begin : g_latn
    localparam int RAW_W = 2 + 5 * DATA_W;
    logic [RAW_W-1:0] raw_q;
    logic             raw_vld;
    logic [PAY_W-1:0] stg_q   [2:LATENCY];
    logic             stg_vld [2:LATENCY];

    mult_cell_slice #(.W(RAW_W)) u_s1 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
      .in_valid(acc),
      .in_data({op, pp_hh, pp_hl, pp_lh, pp_ll, corr}),
      .out_valid(raw_vld), .out_data(raw_q)
    );

    mult_cell_slice #(.W(PAY_W)) u_s2 (
      .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
      .in_valid(raw_vld),
      .in_data({raw_q[RAW_W-1 -: 2],
                pp_sum(raw_q[2*DATA_W-1 -: DATA_W], raw_q[3*DATA_W-1 -: DATA_W],
                       raw_q[4*DATA_W-1 -: DATA_W], raw_q[5*DATA_W-1 -: DATA_W],
                       raw_q[DATA_W-1:0])}),
      .out_valid(stg_vld[2]), .out_data(stg_q[2])
    );

    for (genvar k = 3; k <= LATENCY; k++) begin : g_dly
      mult_cell_slice #(.W(PAY_W)) u_sk (
        .clk(clk), .reset_n(reset_n), .en(en), .flush(flush),
        .in_valid(stg_vld[k-1]), .in_data(stg_q[k-1]),
        .out_valid(stg_vld[k]), .out_data(stg_q[k])
      );
    end

    assign tail_q   = stg_q[LATENCY];
    assign tail_vld = stg_vld[LATENCY];
  end

  assign tail_op   = tail_q[PAY_W-1 -: 2];
  assign tail_prod = tail_q[PW-1:0];
  assign out_valid = tail_vld;
  assign result    = is_high(op_e'(tail_op)) ? tail_prod[PW-1:DATA_W] : tail_prod[DATA_W-1:0];

endmodule

// File: tb/tb_mult_cell_pipe.sv
// Directed and randomized checks of mult_cell_pipe against a 64-bit arithmetic reference and an in-order scoreboard.
module tb_mult_cell_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1, src2;
  logic [1:0]  op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;
  logic [31:0] sbq[$];
  logic [31:0] bp_res[$];
  logic [31:0] sb_exp;

  mult_cell_pipe #(.DATA_W(32), .LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .op(op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    longint x, y, p;
    x = (o == 2'd2 || o == 2'd3) ? longint'($signed(a)) : longint'({32'b0, a});
    y = (o == 2'd3)              ? longint'($signed(b)) : longint'({32'b0, b});
    p = x * y;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Scoreboard: output handshake is retired before this cycle's flush/accept is applied.
  always @(negedge clk) begin
    if (!reset_n) begin
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("sb_extra", {63'b0, out_valid}, 64'd0);
        else begin
          sb_exp = sbq.pop_front();
          chk("sb_res", {32'b0, result}, {32'b0, sb_exp});
        end
      end
      if (flush) sbq.delete();
      else if (in_valid && in_ready) begin
        sbq.push_back(ref_mul(src1, src2, op));
        n_acc++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    in_valid = 1'b1;
    src1 = a;
    src2 = b;
    op = o;
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         input logic [31:0] e, input string tag);
    out_ready = 1'b1;
    drive(a, b, o);
    @(negedge clk); chk({tag, "_rdy"}, {63'b0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk({tag, "_early"}, {63'b0, out_valid}, 64'd0);
    step();
    @(negedge clk);
    chk({tag, "_vld"}, {63'b0, out_valid}, 64'd1);
    chk(tag, {32'b0, result}, {32'b0, e});
    step();
  endtask

  initial begin
    logic [31:0] ff_exp [4];
    int k;
    int base;
    logic fire;
    ff_exp[0] = 32'h0000_0001; ff_exp[1] = 32'hFFFF_FFFE;
    ff_exp[2] = 32'hFFFF_FFFF; ff_exp[3] = 32'h0000_0000;

    reset_n = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0; op = '0;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_vld", {63'b0, out_valid}, 64'd0);
    chk("rst_res", {32'b0, result}, 64'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk); chk("rst_rdy", {63'b0, in_ready}, 64'd1);
    step();

    // Reset with two ops in flight (output stalled so both are held).
    out_ready = 1'b0;
    drive(32'd5, 32'd7, 2'd0); step();
    drive(32'd11, 32'd13, 2'd0); step();
    in_valid = 1'b0;
    @(negedge clk); chk("rst_pre_vld", {63'b0, out_valid}, 64'd1);
    step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_vld", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_res", {32'b0, result}, 64'd0);
    step();
    reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_post_rdy", {63'b0, in_ready}, 64'd1);
    chk("rst_post_res", {32'b0, result}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_stale", {63'b0, out_valid}, 64'd0);
      step();
      @(negedge clk);
    end
    step();

    // All-ones operands, four ops back to back.
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, c[1:0]);
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 2) chk("ff_early", {63'b0, out_valid}, 64'd0);
      else begin
        chk("ff_vld", {63'b0, out_valid}, 64'd1);
        chk("ff_res", {32'b0, result}, {32'b0, ff_exp[c-2]});
      end
      step();
    end
    @(negedge clk); chk("ff_done", {63'b0, out_valid}, 64'd0);
    step();

    run_one(32'h0001_0000, 32'h0001_0000, 2'd0, 32'h0000_0000, "carry_mul");
    run_one(32'h0001_0000, 32'h0001_0000, 2'd1, 32'h0000_0001, "carry_mulxuu");
    run_one(32'h8000_0000, 32'h8000_0000, 2'd3, 32'h4000_0000, "min_mulxss");

    // Back-pressure: six ops 3*k, out_ready low on cycles 3..5.
    k = 1;
    drive(32'd3, 32'd1, 2'd0);
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      chk("bp_in_ready", {63'b0, in_ready}, {63'b0, out_ready});
      if (out_valid && out_ready) bp_res.push_back(result);
      fire = in_valid && in_ready;
      step();
      if (fire) begin
        if (k < 6) begin k++; drive(32'd3, k, 2'd0); end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    chk("bp_count", bp_res.size(), 64'd6);
    for (int i = 0; i < bp_res.size() && i < 6; i++)
      chk("bp_res", {32'b0, bp_res[i]}, 3 * (i + 1));

    // Flush kills the op in slice 1 and the op accepted in the flush cycle.
    drive(32'd2, 32'd3, 2'd0); step();
    drive(32'd4, 32'd5, 2'd0); flush = 1'b1; step();
    in_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("fl_vld", {63'b0, out_valid}, 64'd0);
      step();
    end
    run_one(32'd7, 32'd9, 2'd0, 32'd63, "fl_after");

    // Random regression with random back-pressure and occasional flush.
    base = n_acc;
    for (int c = 0; c < 40000 && (n_acc - base) < 10000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      src1      = $urandom;
      src2      = $urandom;
      op        = 2'($urandom % 4);
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 128) == 0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk("rand_drain", sbq.size(), 64'd0);
    chk("rand_idle", {63'b0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
